// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch feeding a decoder; optional FETCH_BYPASS_EN forwards a response straight to instr.
// Latency: issue N -> mem_data N+1 -> instr_valid N+2 (N+1 when FETCH_BYPASS_EN is defined and the FIFO is empty).
// Backpressure: instr_ready low stalls issue once FIFO entries + in-flight read reach 2; redirect flushes everything.

// fetch_fifo: small generic FIFO with synchronous flush.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: none internally; the caller must never push when full or pop when empty.
module fetch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_vld,
    output logic [WIDTH-1:0] head_dat,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_vld) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop_vld) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            cnt_d = cnt_q + CW'(push_vld) - CW'(pop_vld);
        end
    end

    // Storage is cleared on reset so the head reads as zero until the first push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign count    = cnt_q;

endmodule

module fetch_unit #(
    parameter int                   addr_size = 8,
    parameter int                   data_size = 8,
    parameter logic [addr_size-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 rd_en,
    output logic [addr_size-1:0] rd_adress,
    input  logic [data_size-1:0] mem_data,
    output logic [data_size-1:0] instr,
    output logic [addr_size-1:0] instr_pc,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    input  logic                 redirect,
    input  logic [addr_size-1:0] redirect_pc,
    input  logic                 halt
);

    typedef struct packed {
        logic [addr_size-1:0] pc;
        logic [data_size-1:0] instr;
    } fetch_ent_t;

    logic [addr_size-1:0] pc_q, pc_d;
    logic [addr_size-1:0] req_pc_q, req_pc_d;
    logic                 inflight_q, inflight_d;

    fetch_ent_t head_ent;
    fetch_ent_t push_ent;
    logic [1:0] fifo_cnt;
    logic       fifo_push;
    logic       fifo_pop;
    logic       resp_vld;
    logic       issue;
    logic [2:0] credits_used;

    // A response is only meaningful if no redirect has cancelled it this cycle.
    assign resp_vld = inflight_q & ~redirect;
    assign fifo_pop = (fifo_cnt != 2'd0) & instr_ready & ~redirect;

    // A slot freed by this cycle's pop counts as available, so a ready decoder
    // sustains one fetch per cycle while the in-flight response still has room.
    assign credits_used = 3'(fifo_cnt) - 3'(fifo_pop) + 3'(inflight_q);
    assign issue        = ~rst & ~redirect & ~halt & (credits_used < 3'd2);

    assign push_ent.pc    = req_pc_q;
    assign push_ent.instr = mem_data;

`ifdef FETCH_BYPASS_EN
    logic bypass_vld;
    assign bypass_vld = resp_vld & (fifo_cnt == 2'd0);
    assign fifo_push  = resp_vld & ~(bypass_vld & instr_ready);
`else
    assign fifo_push  = resp_vld;
`endif

    fetch_fifo #(
        .WIDTH ($bits(fetch_ent_t)),
        .DEPTH (2)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect),
        .push_vld (fifo_push),
        .push_dat (push_ent),
        .pop_vld  (fifo_pop),
        .head_dat (head_ent),
        .count    (fifo_cnt)
    );

    always_comb begin
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = issue;
        if (redirect) begin
            pc_d = redirect_pc;
        end else if (issue) begin
            pc_d     = pc_q + addr_size'(1);
            req_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= RESET_PC;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
        end
    end

    assign rd_en     = issue;
    assign rd_adress = pc_q;

    always_comb begin
        instr_valid = ~redirect & (fifo_cnt != 2'd0);
        instr       = head_ent.instr;
        instr_pc    = head_ent.pc;
`ifdef FETCH_BYPASS_EN
        if (bypass_vld) begin
            instr_valid = 1'b1;
            instr       = mem_data;
            instr_pc    = req_pc_q;
        end
`endif
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, backpressure, redirect, wrap, halt and async reset.
module tb_fetch_unit;

`ifdef FETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic       clk         = 1'b0;
    logic       rst         = 1'b1;
    logic       rd_en;
    logic [7:0] rd_adress;
    logic [7:0] mem_data    = 8'h00;
    logic [7:0] instr;
    logic [7:0] instr_pc;
    logic       instr_valid;
    logic       instr_ready = 1'b1;
    logic       redirect    = 1'b0;
    logic [7:0] redirect_pc = 8'h00;
    logic       halt        = 1'b0;

    int checks   = 0;
    int failures = 0;

    logic [31:0] s_rd_en, s_addr, s_vld, s_instr, s_pc;
    logic [31:0] acc_pc[$];
    logic [31:0] acc_instr[$];
    int          n_rd;

    fetch_unit #(
        .addr_size (8),
        .data_size (8),
        .RESET_PC  (8'h00)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_en       (rd_en),
        .rd_adress   (rd_adress),
        .mem_data    (mem_data),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt)
    );

    always #5 clk = ~clk;

    // Program memory contents: fixed words at 0..3, elsewhere address ^ 0xC3.
    function automatic logic [31:0] memval(input int a);
        case (a & 'hFF)
            0:       return 32'h11;
            1:       return 32'h22;
            2:       return 32'h33;
            3:       return 32'h44;
            default: return 32'((a ^ 'hC3) & 'hFF);
        endcase
    endfunction

    always @(posedge clk) begin
        if (rd_en) mem_data <= 8'(memval(int'(rd_adress)));
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic clear_log();
        acc_pc.delete();
        acc_instr.delete();
        n_rd = 0;
    endtask

    // One clock cycle: sample at the falling edge, return just after the next rising edge.
    task automatic cyc();
        @(negedge clk);
        s_rd_en = 32'(rd_en);
        s_addr  = 32'(rd_adress);
        s_vld   = 32'(instr_valid);
        s_instr = 32'(instr);
        s_pc    = 32'(instr_pc);
        if (rd_en) n_rd++;
        if (instr_valid && instr_ready) begin
            acc_pc.push_back(32'(instr_pc));
            acc_instr.push_back(32'(instr));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic rdy);
        rst         = 1'b1;
        redirect    = 1'b0;
        halt        = 1'b0;
        instr_ready = rdy;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_log();
    endtask

    // Free-running stream from address 0 with a ready decoder.
    task automatic run_stream(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            cyc();
            chk($sformatf("%s_rd_en%0d", tag, k), s_rd_en, 32'd1);
            chk($sformatf("%s_addr%0d", tag, k), s_addr, 32'(k));
            chk($sformatf("%s_vld%0d", tag, k), s_vld, 32'(k >= LAT));
            if (k >= LAT) begin
                chk($sformatf("%s_pc%0d", tag, k), s_pc, 32'(k - LAT));
                chk($sformatf("%s_instr%0d", tag, k), s_instr, memval(k - LAT));
            end
        end
    endtask

    initial begin
        logic [31:0] exp_a [3];
        logic [31:0] exp_i [3];
        exp_a = '{32'hFE, 32'hFF, 32'h00};
        exp_i = '{32'h3D, 32'h3C, 32'h11};

        #2;
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        chk("rst_vld", 32'(instr_valid), 32'd0);
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_pc", 32'(instr_pc), 32'd0);
        chk("rst_addr", 32'(rd_adress), 32'd0);

        // Streaming after reset release.
        do_reset(1'b1);
        run_stream("stream", 6);

        // Decoder stalled for five cycles, then released.
        do_reset(1'b0);
        for (int k = 0; k < 5; k++) begin
            cyc();
            if (k >= LAT) begin
                chk($sformatf("bp_hold_vld%0d", k), s_vld, 32'd1);
                chk($sformatf("bp_hold_instr%0d", k), s_instr, 32'h11);
                chk($sformatf("bp_hold_pc%0d", k), s_pc, 32'h00);
            end
        end
        chk("bp_reads", 32'(n_rd), 32'd2);
        chk("bp_rd_en_held", s_rd_en, 32'd0);
        instr_ready = 1'b1;
        repeat (6) cyc();
        chk("bp_count", 32'(acc_pc.size() >= 4), 32'd1);
        for (int i = 0; i < 4 && i < acc_pc.size(); i++) begin
            chk($sformatf("bp_pc%0d", i), acc_pc[i], 32'(i));
            chk($sformatf("bp_instr%0d", i), acc_instr[i], memval(i));
        end

        // Redirect with one queued word and one read in flight.
        do_reset(1'b0);
        repeat (2) cyc();
        redirect    = 1'b1;
        redirect_pc = 8'h80;
        instr_ready = 1'b1;
        cyc();
        chk("rdr_vld", s_vld, 32'd0);
        chk("rdr_rd_en", s_rd_en, 32'd0);
        redirect = 1'b0;
        cyc();
        chk("rdr_next_rd_en", s_rd_en, 32'd1);
        chk("rdr_next_addr", s_addr, 32'h80);
        repeat (4) cyc();
        chk("rdr_count", 32'(acc_pc.size() >= 2), 32'd1);
        if (acc_pc.size() >= 2) begin
            chk("rdr_pc0", acc_pc[0], 32'h80);
            chk("rdr_instr0", acc_instr[0], 32'h43);
            chk("rdr_pc1", acc_pc[1], 32'h81);
            chk("rdr_instr1", acc_instr[1], 32'h42);
        end

        // Address wrap from 0xFE through 0x00.
        do_reset(1'b1);
        redirect    = 1'b1;
        redirect_pc = 8'hFE;
        cyc();
        chk("wrap_rdr_rd_en", s_rd_en, 32'd0);
        redirect = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk($sformatf("wrap_addr%0d", k), s_addr, exp_a[k]);
        end
        repeat (3) cyc();
        chk("wrap_count", 32'(acc_pc.size() >= 3), 32'd1);
        for (int i = 0; i < 3 && i < acc_pc.size(); i++) begin
            chk($sformatf("wrap_pc%0d", i), acc_pc[i], exp_a[i]);
            chk($sformatf("wrap_instr%0d", i), acc_instr[i], exp_i[i]);
        end

        // Halt with a read in flight.
        do_reset(1'b1);
        cyc();
        halt = 1'b1;
        clear_log();
        repeat (4) cyc();
        chk("halt_reads", 32'(n_rd), 32'd0);
        chk("halt_delivered", 32'(acc_pc.size()), 32'd1);
        if (acc_pc.size() >= 1) begin
            chk("halt_pc", acc_pc[0], 32'h00);
            chk("halt_instr", acc_instr[0], 32'h11);
        end
        halt = 1'b0;
        cyc();
        chk("halt_resume_rd_en", s_rd_en, 32'd1);
        chk("halt_resume_addr", s_addr, 32'h01);

        // Asynchronous reset with the FIFO full.
        do_reset(1'b0);
        repeat (4) cyc();
        instr_ready = 1'b1;
        #1;
        chk("arst_pre_vld", 32'(instr_valid), 32'd1);
        chk("arst_pre_rd_en", 32'(rd_en), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_vld", 32'(instr_valid), 32'd0);
        chk("arst_rd_en", 32'(rd_en), 32'd0);
        chk("arst_instr", 32'(instr), 32'd0);
        chk("arst_pc", 32'(instr_pc), 32'd0);
        chk("arst_addr", 32'(rd_adress), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_log();
        run_stream("restart", 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter addr_size, default 8, memory address width in bits.
REQ-002 SHALL have parameter data_size, default 8, instruction/memory word width in bits.
REQ-003 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port rd_en  output  1  read request to program memory.
REQ-007 SHALL have port rd_adress  output  addr_size  read address to program memory.
REQ-008 SHALL have port mem_data  input  data_size  memory read data, valid the cycle after rd_en.
REQ-009 SHALL have port instr  output  data_size  instruction word to decoder.
REQ-010 SHALL have port instr_pc  output  addr_size  address of instr.
REQ-011 SHALL have port instr_valid  output  1  instr/instr_pc valid.
REQ-012 SHALL have port instr_ready  input  1  decoder accepts instr.
REQ-013 SHALL have port redirect  input  1  branch/jump taken; flush and refetch.
REQ-014 SHALL have port redirect_pc  input  addr_size  new fetch address.
REQ-015 SHALL have port halt  input  1  stop issuing new reads.

Function
REQ-016 SHALL hold pc (next fetch address), a 1-bit inflight flag with its request address, and a 2-entry FIFO of {instr_pc, instr}.
REQ-017 SHALL drive rd_en=1, rd_adress=pc and increment pc modulo 2^addr_size when halt=0, redirect=0 and (FIFO count + inflight) < 2.
REQ-018 SHALL wrap pc from 2^addr_size-1 to 0 without any other effect.
REQ-019 SHALL capture mem_data the cycle after an issued read (inflight=1) and push {request address, mem_data} into the FIFO.
REQ-020 SHALL present the FIFO head on instr/instr_pc with instr_valid=1 whenever FIFO non-empty; pop on instr_valid & instr_ready.
REQ-021 SHALL keep instr/instr_pc stable while instr_valid=1 and instr_ready=0.
REQ-022 SHALL support push and pop in the same cycle with count unchanged and order preserved.
REQ-023 SHALL never overflow the FIFO; the credit rule of REQ-017 guarantees space for every in-flight response.
REQ-024 SHALL on redirect=1: drive rd_en=0 and instr_valid=0, ignore instr_ready, discard any returning mem_data, empty the FIFO, clear inflight and load pc=redirect_pc at the edge.
REQ-025 SHALL issue from redirect_pc in the cycle after redirect if halt=0; redirect has priority over halt.
REQ-026 SHALL on halt=1 stop issuing only; in-flight response still completes and FIFO still drains.
REQ-027 SHALL have latency issue cycle N -> mem_data at N+1 -> instr_valid at N+2 (no bypass).

Reset
REQ-028 SHALL on rst=1, asynchronously: pc=RESET_PC, inflight=0, FIFO empty, rd_en=0, instr_valid=0, instr=0, instr_pc=0, rd_adress=RESET_PC.
REQ-029 SHALL discard a response whose request was issued before or during reset; first issue in the first cycle after rst deasserts.

Configuration
REQ-030 SHALL provide macro FETCH_BYPASS_EN.
REQ-031 SHALL with FETCH_BYPASS_EN defined, when FIFO empty and a response returns, drive instr=mem_data, instr_pc=request address, instr_valid=1 combinationally (latency N+1); if instr_ready=1 that cycle the word is not pushed.
REQ-032 SHALL without FETCH_BYPASS_EN, register every response through the FIFO (REQ-027); no combinational path mem_data -> instr.

Verification
REQ-033 SHALL cover: reset release, instr_ready=1, memory[0..3]=0x11,0x22,0x33,0x44 -> rd_adress 0,1,2,... one per cycle; instr 0x11@pc0 at cycle 2, then one per cycle.
REQ-034 SHALL cover: instr_ready=0 for 5 cycles -> rd_en issues exactly 2 reads then holds 0; instr held at 0x11/pc0; ready=1 -> 0x11,0x22,0x33 in order, no loss or duplicate.
REQ-035 SHALL cover: redirect=1, redirect_pc=0x80 while inflight=1 and FIFO holds 1 entry -> instr_valid=0 that cycle; next rd_adress=0x80; first instr_pc=0x80, no stale word delivered.
REQ-036 SHALL cover: pc=0xFE, free-running -> rd_adress 0xFE,0xFF,0x00; instr_pc sequence 0xFE,0xFF,0x00.
REQ-037 SHALL cover: halt=1 with inflight=1 -> response delivered, no further rd_en; halt=0 -> resumes at next sequential address.
REQ-038 SHALL cover: rst asserted mid-stream with FIFO full -> instr_valid=0 and rd_en=0 immediately (asynchronous); after release fetch restarts at RESET_PC; run with and without FETCH_BYPASS_EN (first instr at cycle 1 vs 2).
